// File: rtl/dct_mac_if.sv
// Request handshake and MAC control bundle between the DCT block control,
// the MAC sequencer and the multiply-accumulate datapath it steers.
interface dct_mac_if #(
    parameter int IDX_W = 3,
    parameter int ROW_W = 3
);
    logic             start_valid;
    logic [ROW_W-1:0] coef_row;
    logic             start_ready;
    logic [IDX_W-1:0] mac_sel;
    logic [ROW_W-1:0] mac_row;
    logic             mult_en;
    logic             acc_en;
    logic             acc_clr;
    logic             res_valid;
    logic [ROW_W-1:0] res_row;
    logic             busy;

    modport master (
        output start_valid, coef_row,
        input  start_ready, mac_sel, mac_row, mult_en, acc_en, acc_clr,
               res_valid, res_row, busy
    );

    modport slave (
        input  start_valid, coef_row,
        output start_ready, mac_sel, mac_row, mult_en, acc_en, acc_clr,
               res_valid, res_row, busy
    );
endinterface

// File: rtl/dct_mac_sequencer.sv
// Steps one DCT MAC through an N_TAPS-point dot product per request and
// aligns accumulator controls with a tag pipeline that follows the datapath.
module dct_mac_sequencer #(
    parameter int N_TAPS  = 8,
    parameter int IDX_W   = 3,
    parameter int ROW_W   = 3,
    parameter int MAC_LAT = 2
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     stall,
    dct_mac_if.slave mac
);
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    localparam logic [IDX_W-1:0] K_LAST = IDX_W'(N_TAPS - 1);

    state_t           state_r, state_s;
    logic [IDX_W-1:0] k_r, k_s;
    logic [IDX_W-1:0] sel_r, sel_s;
    logic [ROW_W-1:0] row_r, row_s;
    logic             last_tap_s, ready_s, accept_s, issue_s;

    // Tag stage i carries {valid, first, last, row} for the tap i+1 cycles behind issue
    logic [MAC_LAT-1:0] tag_valid_r, tag_first_r, tag_last_r;
    logic [ROW_W-1:0]   tag_row_r [MAC_LAT];

    assign last_tap_s = (k_r == K_LAST);
    assign ready_s    = !rst && !stall &&
                        ((state_r == IDLE) || ((state_r == ISSUE) && last_tap_s));
    assign accept_s   = ready_s && mac.start_valid;
    assign issue_s    = (state_r == ISSUE) && !stall && !rst;

    // State, tap counter, row and last-issued index registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            k_r     <= {IDX_W{1'b0}};
            sel_r   <= {IDX_W{1'b0}};
            row_r   <= {ROW_W{1'b0}};
        end else begin
            state_r <= state_s;
            k_r     <= k_s;
            sel_r   <= sel_s;
            row_r   <= row_s;
        end
    end

    // Next-state logic; accepting in the final tap restarts k with no bubble
    always_comb begin
        state_s = state_r;
        k_s     = k_r;
        row_s   = row_r;
        if (issue_s) begin
            sel_s = k_r;
        end else begin
            sel_s = sel_r;
        end
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_s = ISSUE;
                    k_s     = {IDX_W{1'b0}};
                    row_s   = mac.coef_row;
                end else begin
                    state_s = IDLE;
                end
            end
            ISSUE: begin
                if (stall) begin
                    state_s = ISSUE;
                end else if (accept_s) begin
                    k_s   = {IDX_W{1'b0}};
                    row_s = mac.coef_row;
                end else if (last_tap_s) begin
                    state_s = IDLE;
                    k_s     = {IDX_W{1'b0}};
                end else begin
                    k_s = k_r + IDX_W'(1);
                end
            end
            default: begin
                state_s = IDLE;
                k_s     = {IDX_W{1'b0}};
            end
        endcase
    end

    // Tag pipeline shifts only on non-stalled cycles so pending results survive a stall
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_valid_r <= {MAC_LAT{1'b0}};
            tag_first_r <= {MAC_LAT{1'b0}};
            tag_last_r  <= {MAC_LAT{1'b0}};
            for (int i = 0; i < MAC_LAT; i++) begin
                tag_row_r[i] <= {ROW_W{1'b0}};
            end
        end else if (!stall) begin
            tag_valid_r  <= {tag_valid_r[MAC_LAT-2:0], issue_s};
            tag_first_r  <= {tag_first_r[MAC_LAT-2:0], (k_r == {IDX_W{1'b0}})};
            tag_last_r   <= {tag_last_r[MAC_LAT-2:0], last_tap_s};
            tag_row_r[0] <= row_r;
            for (int i = 1; i < MAC_LAT; i++) begin
                tag_row_r[i] <= tag_row_r[i-1];
            end
        end else begin
            tag_valid_r <= tag_valid_r;
            tag_first_r <= tag_first_r;
            tag_last_r  <= tag_last_r;
        end
    end

    assign mac.start_ready = ready_s;
    assign mac.mult_en     = issue_s;
    assign mac.mac_sel     = (state_r == ISSUE) ? k_r : sel_r;
    assign mac.mac_row     = row_r;
    assign mac.acc_en      = tag_valid_r[MAC_LAT-2] && !stall && !rst;
    assign mac.acc_clr     = mac.acc_en && tag_first_r[MAC_LAT-2];
    assign mac.res_valid   = tag_valid_r[MAC_LAT-1] && tag_last_r[MAC_LAT-1] && !stall && !rst;
    assign mac.res_row     = tag_row_r[MAC_LAT-1];
    assign mac.busy        = (state_r == ISSUE) || (|tag_valid_r);
endmodule

// File: tb/tb_dct_mac_sequencer.sv
// Bench for dct_mac_sequencer: two instances (MAC_LAT 2 and 3) share stimulus and
// are compared every cycle against a queue-based model, plus literal directed cases.
module tb_dct_mac_sequencer;
    localparam int N = 8;

    logic       clk = 1'b0;
    logic       rst, stl, sv;
    logic [2:0] crow;

    int n_pass  = 0;
    int n_total = 0;

    dct_mac_if #(.IDX_W(3), .ROW_W(3)) if2 ();
    dct_mac_if #(.IDX_W(3), .ROW_W(3)) if3 ();

    assign if2.start_valid = sv;
    assign if2.coef_row    = crow;
    assign if3.start_valid = sv;
    assign if3.coef_row    = crow;

    dct_mac_sequencer #(.N_TAPS(8), .IDX_W(3), .ROW_W(3), .MAC_LAT(2)) dut2 (
        .clk(clk), .rst(rst), .stall(stl), .mac(if2.slave));
    dct_mac_sequencer #(.N_TAPS(8), .IDX_W(3), .ROW_W(3), .MAC_LAT(3)) dut3 (
        .clk(clk), .rst(rst), .stall(stl), .mac(if3.slave));

    always #5 clk = ~clk;

    task automatic chk(input string name, input int lat, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s (lat%0d): got %0d, expected %0d at %0t", name, lat, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    // iq: taps still to be issued, in order. hist: one record per non-stalled cycle.
    typedef struct {bit v; int tap; int row;} rec_t;
    rec_t iq[$];
    rec_t hist[$];
    int   hold_tap = 0, hold_row = 0;
    bit   e_ready;

    function automatic rec_t h(input int n);
        rec_t z;
        z = '{v: 1'b0, tap: 0, row: 0};
        if (n >= 1 && hist.size() >= n) z = hist[hist.size() - n];
        return z;
    endfunction

    task automatic check_dut(input int L, input logic rdy, me, ae, ac, rv, bz,
                             input logic [2:0] sel, mrow, rrow);
        rec_t a, b;
        bit e_bz;
        a = h(L - 1);
        b = h(L);
        e_bz = (iq.size() > 0);
        for (int n = 1; n <= L; n++) if (h(n).v) e_bz = 1'b1;
        chk("start_ready", L, int'(rdy), int'(e_ready));
        chk("mult_en", L, int'(me), int'(!stl && iq.size() > 0));
        chk("mac_sel", L, int'(sel), (iq.size() > 0) ? iq[0].tap : hold_tap);
        chk("mac_row", L, int'(mrow), (iq.size() > 0) ? iq[0].row : hold_row);
        chk("acc_en", L, int'(ae), int'(!stl && a.v));
        chk("acc_clr", L, int'(ac), int'(!stl && a.v && a.tap == 0));
        chk("res_valid", L, int'(rv), int'(!stl && b.v && b.tap == N - 1));
        if (!stl && b.v && b.tap == N - 1) chk("res_row", L, int'(rrow), b.row);
        chk("busy", L, int'(bz), int'(e_bz));
    endtask

    // Compare process: check both DUTs, then advance the model to the next edge
    always @(negedge clk) begin
        rec_t r;
        if (rst) begin
            chk("ready_in_rst", 2, int'(if2.start_ready), 0);
            chk("ready_in_rst", 3, int'(if3.start_ready), 0);
            iq.delete();
            hist.delete();
            hold_tap = 0;
            hold_row = 0;
        end else begin
            e_ready = !stl && iq.size() <= 1;
            check_dut(2, if2.start_ready, if2.mult_en, if2.acc_en, if2.acc_clr,
                      if2.res_valid, if2.busy, if2.mac_sel, if2.mac_row, if2.res_row);
            check_dut(3, if3.start_ready, if3.mult_en, if3.acc_en, if3.acc_clr,
                      if3.res_valid, if3.busy, if3.mac_sel, if3.mac_row, if3.res_row);
            if (!stl) begin
                r.v   = (iq.size() > 0);
                r.tap = r.v ? iq[0].tap : 0;
                r.row = r.v ? iq[0].row : 0;
                hist.push_back(r);
                if (hist.size() > 4) void'(hist.pop_front());
                if (iq.size() > 0) begin
                    hold_tap = iq[0].tap;
                    hold_row = iq[0].row;
                    void'(iq.pop_front());
                end
                if (sv && e_ready)
                    for (int t = 0; t < N; t++) iq.push_back('{v: 1'b1, tap: t, row: int'(crow)});
            end
        end
    end

    // ---------------- directed scenarios with literal expectations ----------------
    // Accept row at cycle 0; optional second row held from cycle 1; optional stall
    // window and reset cycle. Checks first/last res_valid cycle and pulse count.
    task automatic directed(input int row, input int row2, input int s_from, input int s_to,
                            input int r_cyc, input int f2, input int l2, input int f3,
                            input int l3, input int e_n, input bit detail);
        int first2 = -1, last2 = -1, n2 = 0;
        int first3 = -1, last3 = -1, n3 = 0;
        for (int c = 0; c <= 22; c++) begin
            sv   = (c == 0) || (row2 >= 0 && c >= 1 && c <= 8);
            crow = (c == 0) ? 3'(row) : 3'(row2);
            stl  = (c >= s_from && c <= s_to);
            rst  = (c == r_cyc);
            @(negedge clk);
            if (if2.res_valid) begin
                chk("d_res_row", 2, int'(if2.res_row), (n2 == 0) ? row : row2);
                if (first2 < 0) first2 = c;
                last2 = c;
                n2++;
            end
            if (if3.res_valid) begin
                chk("d_res_row", 3, int'(if3.res_row), (n3 == 0) ? row : row2);
                if (first3 < 0) first3 = c;
                last3 = c;
                n3++;
            end
            if (detail && c <= 11) begin
                chk("d_mult_en", 2, int'(if2.mult_en), int'(c >= 1 && c <= 8));
                chk("d_mac_sel", 2, int'(if2.mac_sel), (c >= 1 && c <= 8) ? c - 1 : (c == 0 ? 0 : 7));
                chk("d_acc_en", 2, int'(if2.acc_en), int'(c >= 2 && c <= 9));
                chk("d_acc_clr", 2, int'(if2.acc_clr), int'(c == 2));
                chk("d_acc_en", 3, int'(if3.acc_en), int'(c >= 3 && c <= 10));
                chk("d_acc_clr", 3, int'(if3.acc_clr), int'(c == 3));
                chk("d_busy", 2, int'(if2.busy), int'(c >= 1 && c <= 10));
            end
            if (row2 >= 0 && c <= 15)
                chk("d_b2b_ready", 2, int'(if2.start_ready), int'(c == 0 || c == 8));
            if (c == r_cyc + 1) begin
                chk("d_rst_mult_en", 2, int'(if2.mult_en), 0);
                chk("d_rst_acc_en", 2, int'(if2.acc_en), 0);
                chk("d_rst_busy", 2, int'(if2.busy), 0);
                chk("d_rst_busy", 3, int'(if3.busy), 0);
                chk("d_rst_ready", 2, int'(if2.start_ready), 1);
            end
            @(posedge clk);
            #1;
        end
        chk("d_res_first", 2, first2, f2);
        chk("d_res_last", 2, last2, l2);
        chk("d_res_count", 2, n2, e_n);
        chk("d_res_first", 3, first3, f3);
        chk("d_res_last", 3, last3, l3);
        chk("d_res_count", 3, n3, e_n);
        sv  = 1'b0;
        stl = 1'b0;
        rst = 1'b0;
    endtask

    initial begin
        bit acc;
        rst  = 1'b1;
        stl  = 1'b0;
        sv   = 1'b0;
        crow = 3'd0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", 2, int'(if2.start_ready), 1);
        chk("rst_busy", 2, int'(if2.busy), 0);
        chk("rst_mac_sel", 2, int'(if2.mac_sel), 0);
        chk("rst_mac_row", 2, int'(if2.mac_row), 0);
        chk("rst_res_valid", 3, int'(if3.res_valid), 0);
        @(posedge clk);
        #1;

        directed(5, -1, -1, -1, -1, 10, 10, 11, 11, 1, 1'b1);   // single row
        directed(1, 2, -1, -1, -1, 10, 18, 11, 19, 2, 1'b0);    // back-to-back, second held
        directed(3, -1, 4, 6, -1, 13, 13, 14, 14, 1, 1'b0);     // stall mid-issue
        directed(4, -1, 10, 11, -1, 12, 12, 13, 13, 1, 1'b0);   // stall over result
        directed(6, -1, -1, -1, 5, -1, -1, -1, -1, 0, 1'b0);    // reset aborts row

        // Randomised traffic: requester holds start_valid until accepted
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 199) == 0);
            stl = ($urandom_range(0, 7) == 0);
            @(negedge clk);
            acc = sv && if2.start_ready;
            @(posedge clk);
            #1;
            if (acc || !sv || rst) begin
                sv   = ($urandom_range(0, 2) != 0);
                crow = 3'($urandom_range(0, 7));
            end
        end
        rst = 1'b0;
        stl = 1'b0;
        sv  = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/dct_mac_sequencer.md
Name: dct_mac_sequencer

Overview:
- Sequences one DCT multiply-accumulate unit (multiplier, mult_res register, accumulator) through an N_TAPS-point dot product per request.
- Each request names a coefficient row. The block steps through the sample/coefficient index and drives the mult_res register enable and the accumulator clear/enable with correct pipeline alignment. It pulses res_valid when the accumulator holds the final sum.
- Sits between the DCT block control and each dct_unit MAC inside fdct_zigzag.

Parameters:
N_TAPS, 8, taps per dot product (power of 2, >=2)
IDX_W, 3, width of tap index (log2 N_TAPS)
ROW_W, 3, width of coefficient-row id
MAC_LAT, 2, cycles from mult_en for a tap to the accumulator register holding that tap (>=2)

Ports:
clk  in  1  clock, all logic rising-edge
rst  in  1  synchronous, active-high reset
stall  in  1  global freeze (ena low upstream)
start_valid  in  1  request a dot product
coef_row  in  ROW_W  coefficient row for the request, sampled on accept
start_ready  out  1  request accepted when start_valid & start_ready
mac_sel  out  IDX_W  tap index to sample mux / coefficient ROM column
mac_row  out  ROW_W  coefficient ROM row for current issue
mult_en  out  1  load enable for mult_res register
acc_en  out  1  accumulator update enable
acc_clr  out  1  with acc_en: load product instead of acc+product (first tap)
res_valid  out  1  one-cycle pulse: accumulator holds final sum
res_row  out  ROW_W  row id of the result, valid with res_valid
busy  out  1  issue in progress or any tap in flight

Behaviour:
- FSM states: IDLE, ISSUE. Tap counter k (IDX_W bits), row register.
- start_ready is combinational:
  - It is !stall & (state==IDLE | (state==ISSUE & k==N_TAPS-1)).
  - During the rst cycle it is 0.
- Accept (start_valid & start_ready at an edge):
  - state<=ISSUE, k<=0, row<=coef_row.
  - Accepting in the last ISSUE cycle gives back-to-back rows with no bubble.
- ISSUE (stall=0):
  - mult_en=1, mac_sel=k, mac_row=row.
  - k increments each cycle.
  - At k==N_TAPS-1 without a new accept: state<=IDLE, k<=0.
- IDLE:
  - mult_en=0.
  - mac_sel and mac_row hold their last values (0 after reset).
- Tag pipeline:
  - Stages 1..MAC_LAT carry {valid, first, last, row}.
  - Stage 1 loads {mult_en, k==0, k==N_TAPS-1, row} each non-stalled cycle. Stage s+1 loads from stage s.
  - acc_en = stage[MAC_LAT-1].valid & !stall.
  - acc_clr = acc_en & stage[MAC_LAT-1].first.
  - res_valid = stage[MAC_LAT].valid & stage[MAC_LAT].last & !stall. res_row = stage[MAC_LAT].row.
- Latency with MAC_LAT=2 and accept at cycle 0:
  - mult_en in cycles 1..8.
  - acc_en in cycles 2..9 (acc_clr in cycle 2).
  - res_valid in cycle 10.
- Throughput: one result per N_TAPS cycles sustained. Pipelining of consecutive rows overlaps with no extra control.
- Stall:
  - FSM, k, row and the tag pipeline all freeze.
  - mult_en, acc_en, acc_clr and res_valid are forced 0. start_ready=0.
  - A pending result is reasserted on the first non-stalled cycle, exactly once.
- start_valid while busy and not in the last ISSUE cycle is ignored, not queued. The requester holds start_valid.
- busy = (state==ISSUE) | OR of all stage valids.
- Reset (including mid-operation):
  - state=IDLE, k=0, row=0, all tag stages cleared.
  - All outputs 0 except start_ready, which is 1 from the first cycle after reset if stall=0.
  - No res_valid is produced for aborted rows.
- k wraps only via the explicit N_TAPS-1 transition. No partial dot products are ever reported.

Test Plan:
- Single row, coef_row=5, MAC_LAT=2, accept at cycle 0 -> mult_en cycles 1-8 with mac_sel 0..7 and mac_row=5; acc_clr only in cycle 2; acc_en cycles 2-9; res_valid=1, res_row=5 only in cycle 10; busy falls in cycle 11.
- Back-to-back rows 1 then 2, second accepted in cycle 8 -> mult_en continuous cycles 1-16; acc_clr in cycles 2 and 10; res_valid in cycle 10 (row 1) and cycle 18 (row 2).
- stall=1 for cycles 4-6 during row 3 -> mult_en/acc_en low in cycles 4-6; mac_sel resumes at 3 in cycle 7; res_valid shifts 3 cycles to cycle 13. Stall held during the res_valid cycle -> single pulse after release.
- start_valid held high from cycle 2 while row 0 issues -> no accept until cycle 8; no mac_sel discontinuity.
- rst asserted in cycle 5 of a row -> cycle 6: mult_en=acc_en=res_valid=busy=0, start_ready=1; no res_valid ever appears for that row.
- MAC_LAT=3, row 7 accepted at cycle 0 -> acc_en cycles 3-10, acc_clr cycle 3, res_valid cycle 11.
